// File: rtl/thor2024_rf_source_tracker.sv
// thor2024_rf_source_tracker: per-register producer table ({mem, qid}) with a register-valid bitmap,
// commit-side clearing and full rebuild from surviving queue entries on a branch miss.
module thor2024_rf_source_tracker #(
    parameter int AREGS = 64,
    parameter int QENTRIES = 8,
    parameter int NENQ = 2,
    parameter int NCMT = 2,
    localparam int RW = $clog2(AREGS),
    localparam int QW = $clog2(QENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      branchmiss,
    input  logic [NENQ-1:0]           enq_v,
    input  logic [NENQ-1:0]           enq_rfw,
    input  logic [NENQ*RW-1:0]        enq_tgt,
    input  logic [NENQ-1:0]           enq_mem,
    input  logic [NENQ*QW-1:0]        enq_qid,
    input  logic [NCMT-1:0]           cmt_v,
    input  logic [NCMT*RW-1:0]        cmt_tgt,
    input  logic [NCMT*QW-1:0]        cmt_qid,
    input  logic [QENTRIES-1:0]       rec_v,
    input  logic [QENTRIES*RW-1:0]    rec_tgt,
    input  logic [QENTRIES-1:0]       rec_mem,
    output logic [AREGS*(QW+1)-1:0]   rf_source,
    output logic [AREGS-1:0]          rf_v,
    output logic                      rec_conflict
);
    logic [QW:0] src [AREGS];
    logic [QW:0] src_n [AREGS];
    logic [AREGS-1:0] v, v_n;
    logic [QENTRIES-1:0] killed;
    logic conf_n, hit;
    logic [RW-1:0] t;
    always_comb begin
        src_n = src;
        v_n = v;
        conf_n = 1'b0;
        killed = '0;
        hit = 1'b0;
        t = '0;
        for (int c = 0; c < NCMT; c++)
            if (cmt_v[c]) killed[cmt_qid[c*QW +: QW]] = 1'b1;
        if (branchmiss) begin
            // register 0 is skipped so it keeps its hardwired {0,0}/valid state
            for (int r = 1; r < AREGS; r++) begin
                hit = 1'b0;
                for (int e = 0; e < QENTRIES; e++)
                    if (rec_v[e] && !killed[e] && rec_tgt[e*RW +: RW] == RW'(r)) begin
                        conf_n = conf_n | hit;
                        hit = 1'b1;
                        src_n[r] = {rec_mem[e], QW'(e)};
                    end
                v_n[r] = !hit;
            end
        end else begin
            for (int c = 0; c < NCMT; c++) begin
                t = cmt_tgt[c*RW +: RW];
                if (cmt_v[c] && t != '0 && !v[t] && src[t][QW-1:0] == cmt_qid[c*QW +: QW])
                    v_n[t] = 1'b1;
            end
            // lanes applied oldest first so the youngest writer and any enqueue over a commit win
            for (int l = 0; l < NENQ; l++) begin
                t = enq_tgt[l*RW +: RW];
                if (enq_v[l] && enq_rfw[l] && t != '0) begin
                    src_n[t] = {enq_mem[l], enq_qid[l*QW +: QW]};
                    v_n[t] = 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            src <= '{default: '0};
            v <= '1;
            rec_conflict <= 1'b0;
        end else begin
            src <= src_n;
            v <= v_n;
            rec_conflict <= conf_n;
        end
    for (genvar i = 0; i < AREGS; i++) begin : g_out
        assign rf_source[i*(QW+1) +: QW+1] = src[i];
    end
    assign rf_v = v;
endmodule

// File: doc/thor2024_rf_source_tracker.md
# thor2024_rf_source_tracker

Parametrised register-source tracker for the Thor2024 out-of-order core, sitting between the dispatch stage and the issue queue. It records, per architectural register, which queue entry (and which result bus, ALU or MEM) will produce the register's next value, and whether the register file already holds the committed value. Versus the earlier two-lane tracker it adds:

- N enqueue lanes
- a register-valid bitmap with commit-side clearing
- a hardwired zero register
- full table rebuild on branch miss from per-entry survivor flags

## Interface
Parameters:
- AREGS, 64, number of architectural registers; RW = $clog2(AREGS)
- QENTRIES, 8, issue-queue depth; QW = $clog2(QENTRIES)
- NENQ, 2, enqueue lanes per cycle; lane 0 is oldest
- NCMT, 2, commit lanes per cycle

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- branchmiss  in  1  recovery cycle; table rebuilt from the rec_* inputs
- enq_v  in  NENQ  lane enqueues this cycle
- enq_rfw  in  NENQ  lane writes a register
- enq_tgt  in  NENQ×RW  lane target register
- enq_mem  in  NENQ  result arrives on MEM bus (1) or ALU bus (0)
- enq_qid  in  NENQ×QW  queue entry allocated to the lane
- cmt_v  in  NCMT  commit lane valid
- cmt_tgt  in  NCMT×RW  committed target register
- cmt_qid  in  NCMT×QW  committed queue entry
- rec_v  in  QENTRIES  entry survives the miss and is the latest writer of its target
- rec_tgt  in  QENTRIES×RW  entry target register
- rec_mem  in  QENTRIES  entry MEM flag
- rf_source  out  AREGS×(QW+1)  per register: {mem, qid}
- rf_v  out  AREGS  1 = register file holds the current value
- rec_conflict  out  1  two surviving entries named the same target during recovery

## Operation
Priority per cycle: branchmiss > enqueue > commit.

Normal cycle (branchmiss = 0):
- Enqueue: a lane with enq_v & enq_rfw & enq_tgt≠0 sets rf_source[tgt] = {enq_mem, enq_qid} and rf_v[tgt] = 0.
- If several lanes hit the same tgt, the highest-numbered (youngest) lane wins.
- Commit: a lane with cmt_v sets rf_v[cmt_tgt] = 1 only when rf_source[cmt_tgt].qid == cmt_qid and rf_v[cmt_tgt] == 0. The qid compare ignores the mem bit.
- A stale commit (the source has since been renamed) leaves the register untouched.
- If an enqueue and a commit hit the same register in one cycle, the enqueue wins.

Branchmiss cycle:
- All enqueue inputs are ignored.
- For every register r≠0: if some entry e has rec_v[e] and rec_tgt[e] == r, and e is not being committed this cycle (no cmt lane with cmt_qid == e), then rf_source[r] = {rec_mem[e], e} and rf_v[r] = 0. Otherwise rf_v[r] = 1 and rf_source[r] is unchanged.
- If more than one qualifying entry targets r, the highest index wins, and rec_conflict is asserted the following cycle for one cycle.

Register 0:
- rf_v[0] = 1 and rf_source[0] = 0 always; never written.

## Timing
- All outputs are registered; an update driven in cycle N is visible on the outputs in cycle N+1.
- No combinational path from any input to any output.
- Reset (async assert, deassert sampled on clk): rf_source all 0, rf_v all 1, rec_conflict 0.
- Reset mid-recovery discards the recovery; state is the reset state.
- branchmiss held for several cycles rebuilds every cycle from the current rec_* values. This is idempotent when the inputs are stable.
- rec_conflict is a one-cycle pulse, cleared on the next non-conflicting cycle.
- No internal state beyond the table and the conflict flag. No handshake and no back-pressure: the block always accepts its inputs.

## Test plan
- Reset, then idle: rf_v = all 1s, every rf_source = 0, rec_conflict = 0.
- Two lanes with the same target: lane0 tgt 5 qid 2 mem 0, lane1 tgt 5 qid 3 mem 1, both rfw. Next cycle rf_source[5] = {1, 3} and rf_v[5] = 0.
- Enqueue tgt 7 qid 4, then commit tgt 7 qid 4 → rf_v[7] = 1. Re-enqueue tgt 7 qid 6, then commit tgt 7 qid 4 (stale) → rf_v[7] stays 0 and rf_source[7] = {0, 6}.
- Same-cycle enqueue and commit: enqueue tgt 9 qid 1 while committing tgt 9 with the old qid → rf_v[9] = 0, rf_source[9] = {0, 1}.
- Branch-miss rebuild:
  - Setup: regs 3 and 4 pending on qids 0 and 5.
  - Stimulus: branchmiss with rec_v = 0x01, rec_tgt[0] = 3, rec_mem[0] = 1.
  - Expected: rf_source[3] = {1, 0}, rf_v[3] = 0, rf_v[4] = 1. Enqueue tgt 10 in the same cycle is ignored: rf_v[10] = 1.
- Conflict and register 0: branchmiss with rec_v = 0x06 and rec_tgt[1] = rec_tgt[2] = 12 → rf_source[12].qid = 2 and a one-cycle rec_conflict pulse. Enqueue tgt 0 → rf_v[0] stays 1.
